bool_lut_engine: RTL and testbench

//  Programmable, registered boolean function unit: N_CH independent truth tables over an
//  N_IN-bit input vector, written at run time. Evaluates host vectors (valid/ready) or runs
//  an exhaustive self-sweep of all 2**N_IN input combinations. Generalises the fixed
//  3/4-input expression gates into one configurable block with flow control.

---
 rtl/bool_lut_engine_pkg.sv | 12 +
 rtl/bool_lut_ch.sv | 35 +++
 rtl/bool_lut_engine.sv | 135 +++++++++++++
 tb/tb_bool_lut_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bool_lut_engine_pkg.sv
// Shared constants for the boolean LUT engine: FSM state encodings and legal parameter ranges.
package bool_lut_engine_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam int N_IN_MIN = 1;
    localparam int N_IN_MAX = 6;
    localparam int N_CH_MIN = 1;
    localparam int N_CH_MAX = 8;

endpackage

// File: rtl/bool_lut_ch.sv
// One run-time programmable truth table: a 2**N_IN-bit register with write enable
// and a combinational lookup on the selected input vector.
module bool_lut_ch #(
    parameter  int N_IN  = 4,
    localparam int TBL_W = 1 << N_IN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [TBL_W-1:0] wr_data,
    input  logic [N_IN-1:0]  sel,
    output logic             f
);

    logic [TBL_W-1:0] table_q;
    logic [TBL_W-1:0] table_d;

    always_comb begin
        table_d = table_q;
        if (wr_en) begin
            table_d = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q <= '0;
        end else begin
            table_q <= table_d;
        end
    end

    assign f = table_q[sel];

endmodule

// File: rtl/bool_lut_engine.sv
// Programmable boolean function unit: N_CH truth tables evaluated on host vectors or an
// exhaustive self-sweep, behind a single valid/ready output register.
module bool_lut_engine
    import bool_lut_engine_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int N_CH  = 2,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TBL_W = 1 << N_IN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [TBL_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  out_vec,
    output logic [N_CH-1:0]  out_f,
    output logic             out_last
);

    logic [0:0]      state_q, state_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [N_IN-1:0] out_vec_q, out_vec_d;
    logic [N_CH-1:0] out_f_q, out_f_d;
    logic            out_last_q, out_last_d;

    logic            idle;
    logic            load_en;
    logic            cfg_fire;
    logic [N_IN-1:0] sweep_vec;
    logic            sweep_last;
    logic [N_IN-1:0] sel_vec;
    logic [N_CH-1:0] ch_f;

    assign idle       = (state_q == ST_IDLE);
    assign load_en    = !out_valid_q | out_ready;
    assign cfg_ready  = idle;
    assign in_ready   = idle & load_en;
    assign cfg_fire   = cfg_valid & cfg_ready;
    assign sweep_vec  = cnt_q[N_IN-1:0];
    assign sweep_last = &sweep_vec;
    assign sel_vec    = idle ? in_vec : sweep_vec;

    // Out-of-range cfg_ch values match no channel, so such writes are silently absorbed.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        bool_lut_ch #(
            .N_IN (N_IN)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (cfg_fire && (cfg_ch == CH_W'(gi))),
            .wr_data (cfg_data),
            .sel     (sel_vec),
            .f       (ch_f[gi])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_vec_d   = out_vec_q;
        out_f_d     = out_f_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    out_valid_d = in_valid;
                    if (in_valid) begin
                        out_vec_d  = in_vec;
                        out_f_d    = ch_f;
                        out_last_d = 1'b0;
                    end
                end
                // A host vector taken this cycle goes first; sweep vector 0 follows.
                if (sweep_start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (cnt_q[N_IN]) begin
                    state_d = ST_IDLE;
                end else if (load_en) begin
                    out_valid_d = 1'b1;
                    out_vec_d   = sweep_vec;
                    out_f_d     = ch_f;
                    out_last_d  = sweep_last;
                    cnt_d       = cnt_q + (N_IN+1)'(1);
                    if (sweep_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_f_q     <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_f_q     <= out_f_d;
            out_last_q  <= out_last_d;
        end
    end

    assign sweep_busy = (state_q == ST_SWEEP);
    assign out_valid  = out_valid_q;
    assign out_vec    = out_vec_q;
    assign out_f      = out_f_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_bool_lut_engine.sv
// Directed self-checking bench for bool_lut_engine (N_IN=4, N_CH=3 so cfg_ch can name
// a non-existent channel).
module tb_bool_lut_engine;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_vec;
    logic        sweep_start;
    logic        sweep_busy;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_vec;
    logic [2:0]  out_f;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    bool_lut_engine #(
        .N_IN (4),
        .N_CH (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_data    (cfg_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vec     (out_vec),
        .out_f       (out_f),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep; mode 1 drives out_ready 1,0,0,1 repeating. stop_at >= 0 returns
    // with that vector still displayed so the caller can act on it.
    task automatic run_sweep(input int mode, input logic [15:0] t0, input logic [15:0] t1,
                             input logic [15:0] t2, input int stop_at, input logic cfg_poke);
        int   exp_i;
        logic done;
        logic [2:0] exp_f;
        sweep_start = 1'b1;
        out_ready   = 1'b1;
        tick();
        sweep_start = 1'b0;
        exp_i = 0;
        done  = 1'b0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            if (mode == 1) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            cfg_valid = cfg_poke && !(out_valid && out_vec == 4'hF);
            cfg_ch    = 2'd0;
            cfg_data  = 16'h0000;
            if (out_valid) begin
                exp_f = {t2[exp_i], t1[exp_i], t0[exp_i]};
                $display("sweep mode=%0d vec=%0d f=%b last=%b ready=%b", mode, out_vec, out_f,
                         out_last, out_ready);
                check("sweep_vec", 32'(out_vec), 32'(exp_i));
                check("sweep_f", 32'(out_f), 32'(exp_f));
                check("sweep_last", 32'(out_last), 32'(exp_i == 15));
                check("sweep_busy", 32'(sweep_busy), 32'(exp_i != 15));
                if (exp_i != 15) begin
                    check("sweep_in_ready", 32'(in_ready), 32'd0);
                    check("sweep_cfg_ready", 32'(cfg_ready), 32'd0);
                end
                if (exp_i == stop_at) begin
                    done = 1'b1;
                end else if (out_ready) begin
                    if (exp_i == 15) done = 1'b1;
                    else exp_i++;
                end
            end
            if (exp_i != stop_at || !done) tick();
        end
        cfg_valid = 1'b0;
        check("sweep_completed", 32'(done), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_ch      = 2'd0;
        cfg_data    = 16'h0000;
        in_valid    = 1'b0;
        in_vec      = 4'h0;
        sweep_start = 1'b0;
        out_ready   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        $display("reset: out_valid=%b busy=%b cfg_ready=%b in_ready=%b", out_valid, sweep_busy,
                 cfg_ready, in_ready);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Program tables: ch0 = A&B|~C, ch1 = (A^B)&(C|D), ch2 = D
        cfg_valid = 1'b1;
        cfg_ch = 2'd0; cfg_data = 16'hF333; tick();
        cfg_ch = 2'd1; cfg_data = 16'h0EE0; tick();
        cfg_ch = 2'd2; cfg_data = 16'hAAAA; tick();
        cfg_valid = 1'b0;

        // Host vector 1100
        in_valid = 1'b1;
        in_vec   = 4'b1100;
        tick();
        in_valid = 1'b0;
        $display("host vec=%b f=%b valid=%b last=%b", out_vec, out_f, out_valid, out_last);
        check("host_valid", 32'(out_valid), 32'd1);
        check("host_vec", 32'(out_vec), 32'hC);
        check("host_f", 32'(out_f), 32'b001);
        check("host_last", 32'(out_last), 32'd0);
        tick();
        check("host_drained", 32'(out_valid), 32'd0);

        // Free-running sweep, then stalled sweep with blocked config writes
        run_sweep(0, 16'hF333, 16'h0EE0, 16'hAAAA, -1, 1'b0);
        check("sweep0_busy_after", 32'(sweep_busy), 32'd0);
        check("sweep0_valid_after", 32'(out_valid), 32'd0);
        run_sweep(1, 16'hF333, 16'h0EE0, 16'hAAAA, -1, 1'b1);
        out_ready = 1'b1;
        check("sweep1_busy_after", 32'(sweep_busy), 32'd0);

        // Same-cycle write and evaluate: vector sees the old table
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_data = 16'h0000;
        in_valid  = 1'b1; in_vec = 4'b0000;
        tick();
        cfg_valid = 1'b0;
        $display("same-cycle vec=%b f=%b", out_vec, out_f);
        check("samecyc_f", 32'(out_f), 32'b001);
        tick();
        $display("after-write vec=%b f=%b", out_vec, out_f);
        check("newtbl_f", 32'(out_f), 32'b000);
        in_valid = 1'b0;

        // Write to non-existent channel 3 must change nothing
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_data = 16'hFFFF;
        tick();
        cfg_valid = 1'b0;
        in_valid = 1'b1; in_vec = 4'b0101;
        tick();
        in_valid = 1'b0;
        $display("bad-ch vec=%b f=%b", out_vec, out_f);
        check("badch_f", 32'(out_f), 32'b110);
        tick();

        // Async reset at sweep vector 7
        run_sweep(0, 16'h0000, 16'h0EE0, 16'hAAAA, 7, 1'b0);
        rst = 1'b1;
        #1;
        $display("mid-sweep reset: valid=%b vec=%b f=%b last=%b busy=%b", out_valid, out_vec,
                 out_f, out_last, sweep_busy);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_vec", 32'(out_vec), 32'd0);
        check("arst_f", 32'(out_f), 32'd0);
        check("arst_last", 32'(out_last), 32'd0);
        check("arst_busy", 32'(sweep_busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_idle_valid", 32'(out_valid), 32'd0);
        run_sweep(0, 16'h0000, 16'h0000, 16'h0000, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
